// File: rtl/button_gesture.sv
// Click / double-click / long-press / auto-repeat classifier fed by debounced press/release pulses.
// Optional auto-repeat in HOLD is built only when BUTTON_REPEAT_EN is defined.
module button_gesture #(
  parameter int unsigned LONG_CYCLES   = 25_000_000,
  parameter int unsigned DCLICK_CYCLES = 12_500_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic button_pressed,
  input  logic button_released,
  output logic click,
  output logic double_click,
  output logic long_press,
  output logic repeat_tick,
  output logic busy
);

  localparam int unsigned MAX_LD =
    (LONG_CYCLES > DCLICK_CYCLES) ? LONG_CYCLES : DCLICK_CYCLES;
  localparam int unsigned MAX_C  =
    (MAX_LD > REPEAT_CYCLES) ? MAX_LD : REPEAT_CYCLES;
  localparam int unsigned CW     = $clog2(MAX_C);

  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, HOLD} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic            w_reload;
  logic            w_click;
  logic            w_dclick;
  logic            w_long;
  logic            w_rep;
  logic            r_click;
  logic            r_dclick;
  logic            r_long;
  logic            r_rep;
  logic            r_busy;

  always_comb begin
    w_next   = r_state;
    w_reload = 1'b0;
    w_click  = 1'b0;
    w_dclick = 1'b0;
    w_long   = 1'b0;
    w_rep    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (button_pressed) w_next = PRESS1;
      end
      PRESS1: begin
        if (button_released) begin
          w_next = WAIT2;
        end else if (r_cnt == CW'(LONG_CYCLES - 1)) begin
          w_next = HOLD;
          w_long = 1'b1;
        end
      end
      WAIT2: begin
        if (button_pressed) begin
          w_next   = PRESS2;
          w_dclick = 1'b1;
        end else if (r_cnt == CW'(DCLICK_CYCLES - 1)) begin
          w_next  = IDLE;
          w_click = 1'b1;
        end
      end
      PRESS2: begin
        if (button_released) w_next = IDLE;
      end
      HOLD: begin
        if (button_released) begin
          w_next = IDLE;
`ifdef BUTTON_REPEAT_EN
        end else if (r_cnt == CW'(REPEAT_CYCLES - 1)) begin
          w_rep    = 1'b1;
          w_reload = 1'b1;
`endif
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Saturating increment keeps the counter from wrapping while parked in IDLE/PRESS2.
  always_comb begin
    if ((w_next != r_state) || w_reload) begin
      w_cnt_next = '0;
    end else if (r_cnt != '1) begin
      w_cnt_next = r_cnt + 1'b1;
    end else begin
      w_cnt_next = r_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_click  <= 1'b0;
      r_dclick <= 1'b0;
      r_long   <= 1'b0;
      r_rep    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt_next;
      r_click  <= w_click;
      r_dclick <= w_dclick;
      r_long   <= w_long;
      r_rep    <= w_rep;
      r_busy   <= (w_next != IDLE);
    end
  end

  assign click        = r_click;
  assign double_click = r_dclick;
  assign long_press   = r_long;
  assign repeat_tick  = r_rep;
  assign busy         = r_busy;

endmodule

// File: tb/tb_button_gesture.sv
// Bench for button_gesture: directed gestures plus random press/release traffic against a deadline-based model.
module tb_button_gesture;

  localparam int unsigned LONG_C   = 8;
  localparam int unsigned DCLICK_C = 4;
  localparam int unsigned REPEAT_C = 3;
`ifdef BUTTON_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic button_pressed  = 1'b0;
  logic button_released = 1'b0;
  logic click, double_click, long_press, repeat_tick, busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model: gesture phase plus an absolute-cycle deadline instead of a counter.
  // ph: 0 idle, 1 first press held, 2 released awaiting 2nd press, 3 second press held, 4 long hold
  int ph = 0;
  int dl = 0;
  logic e_click, e_dbl, e_long, e_rep, e_busy;

  button_gesture #(
    .LONG_CYCLES  (LONG_C),
    .DCLICK_CYCLES(DCLICK_C),
    .REPEAT_CYCLES(REPEAT_C)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .button_pressed (button_pressed),
    .button_released(button_released),
    .click          (click),
    .double_click   (double_click),
    .long_press     (long_press),
    .repeat_tick    (repeat_tick),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: got %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("click", click, e_click);
    chk("double_click", double_click, e_dbl);
    chk("long_press", long_press, e_long);
    chk("repeat_tick", repeat_tick, e_rep);
    chk("busy", busy, e_busy);
  endtask

  // One cycle with the given input pulses; outputs checked one cycle later.
  task automatic step(input logic p, input logic r);
    button_pressed  = p;
    button_released = r;
    e_click = 1'b0; e_dbl = 1'b0; e_long = 1'b0; e_rep = 1'b0;
    case (ph)
      0: if (p) begin ph = 1; dl = cyc + int'(LONG_C); end
      1: if (r) begin
           ph = 2; dl = cyc + int'(DCLICK_C);
         end else if (cyc == dl) begin
           ph = 4; e_long = 1'b1; dl = cyc + int'(REPEAT_C);
         end
      2: if (p) begin
           ph = 3; e_dbl = 1'b1;
         end else if (cyc == dl) begin
           ph = 0; e_click = 1'b1;
         end
      3: if (r) ph = 0;
      4: if (r) begin
           ph = 0;
         end else if (cyc == dl) begin
           e_rep = REP_EN;
           dl    = cyc + int'(REPEAT_C);
         end
      default: ph = 0;
    endcase
    e_busy = (ph != 0);
    @(posedge clk);
    #1;
    button_pressed  = 1'b0;
    button_released = 1'b0;
    cyc++;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    ph  = 0;
    e_click = 1'b0; e_dbl = 1'b0; e_long = 1'b0; e_rep = 1'b0; e_busy = 1'b0;
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
    check_all();
  endtask

  initial begin
    e_click = 1'b0; e_dbl = 1'b0; e_long = 1'b0; e_rep = 1'b0; e_busy = 1'b0;
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);

    // single click: press 0, release 3
    step(1'b1, 1'b0); idle(2); step(1'b0, 1'b1); idle(8);
    // double click: press 0, release 2, press 5, release 7
    step(1'b1, 1'b0); idle(1); step(1'b0, 1'b1); idle(2);
    step(1'b1, 1'b0); idle(1); step(1'b0, 1'b1); idle(4);
    // last window cycle press
    step(1'b1, 1'b0); idle(1); step(1'b0, 1'b1); idle(3);
    step(1'b1, 1'b0); step(1'b0, 1'b1); idle(3);
    // press just after window expiry starts a new gesture
    step(1'b1, 1'b0); step(1'b0, 1'b1); idle(4);
    step(1'b1, 1'b0); idle(2); step(1'b0, 1'b1); idle(8);
    // long press with repeats: press 0, release 15
    step(1'b1, 1'b0); idle(14); step(1'b0, 1'b1); idle(5);
    // release coinciding with long threshold
    step(1'b1, 1'b0); idle(7); step(1'b0, 1'b1); idle(7);
    // simultaneous pulses in IDLE, PRESS1, WAIT2
    step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1); idle(2);
    // reset during HOLD, then stray release, then normal click
    idle(2);
    step(1'b1, 1'b0); idle(9);
    do_reset();
    step(1'b0, 1'b1); idle(2);
    step(1'b1, 1'b0); step(1'b0, 1'b1); idle(6);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      logic rp, rr;
      rp = ($urandom_range(0, 7) == 0);
      rr = ($urandom_range(0, 6) == 0);
      step(rp, rr);
      if (($urandom_range(0, 299) == 0)) do_reset();
    end
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete, limit reached");
    $fatal(1, "timeout");
  end

endmodule
